// File: rtl/booth_r4_seq_mult_if.sv
// Handshake/operand bundle for the radix-4 Booth sequential multiplier.
// The optional is_signed wire only exists when BOOTH_UNSIGNED_EN is defined.
interface booth_r4_seq_mult_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     mpcnd;
`ifdef BOOTH_UNSIGNED_EN
   logic                 is_signed;
`endif
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   prd;

`ifdef BOOTH_UNSIGNED_EN
   modport master (output start, mplier, mpcnd, is_signed, input busy, done, prd);
   modport slave  (input start, mplier, mpcnd, is_signed, output busy, done, prd);
`else
   modport master (output start, mplier, mpcnd, input busy, done, prd);
   modport slave  (input start, mplier, mpcnd, output busy, done, prd);
`endif
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per ITER cycle.
// Optional feature macro: BOOTH_UNSIGNED_EN (adds is_signed, unsigned mode takes one extra iteration).
module booth_r4_seq_mult #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   booth_r4_seq_mult_if.slave bus
);
   localparam int AW = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
   localparam int QW = WIDTH + 2;
`else
   localparam int QW = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH / 2 + 2);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t               state_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [2*WIDTH-1:0]   prd_reg;
   logic [AW-1:0]        acc_reg;
   logic [AW-1:0]        m_reg;
   logic [QW-1:0]        q_reg;
   logic                 q_m1_reg;
   logic [CW-1:0]        cnt_reg;
   logic                 uns_reg;

   logic [AW-1:0]        m2;
   logic [AW-1:0]        term;
   logic [AW-1:0]        sum;
   logic [AW-1:0]        acc_next;
   logic [QW-1:0]        q_next;
   logic [2*WIDTH-1:0]   prd_next;
   logic [CW-1:0]        last_cnt;
   logic                 ext_m;
   logic                 ext_q;
   logic                 uns_in;

`ifdef BOOTH_UNSIGNED_EN
   assign uns_in = ~bus.is_signed;
`else
   assign uns_in = 1'b0;
`endif
   assign ext_m    = bus.mpcnd[WIDTH-1] & ~uns_in;
   assign ext_q    = bus.mplier[WIDTH-1] & ~uns_in;
   assign last_cnt = uns_reg ? CW'(WIDTH / 2) : CW'(WIDTH / 2 - 1);

   always_comb begin
      m2 = {m_reg[AW-2:0], 1'b0};
      unique case ({q_reg[1:0], q_m1_reg})
         3'b001, 3'b010: term = m_reg;
         3'b011:         term = m2;
         3'b100:         term = ~m2 + 1'b1;
         3'b101, 3'b110: term = ~m_reg + 1'b1;
         default:        term = '0;
      endcase
      sum      = acc_reg + term;
      acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_next   = {sum[1:0], q_reg[QW-1:2]};
      // Signed runs stop with the (possibly extended) Q's low 2 bits still unretired;
      // unsigned runs consume all of Q, so the acc contributes two fewer bits.
      if (uns_reg)
         prd_next = {acc_next[WIDTH-3:0], q_next[QW-1:QW-WIDTH-2]};
      else
         prd_next = {acc_next[WIDTH-1:0], q_next[QW-1:QW-WIDTH]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         prd_reg   <= '0;
         acc_reg   <= '0;
         m_reg     <= '0;
         q_reg     <= '0;
         q_m1_reg  <= 1'b0;
         cnt_reg   <= '0;
         uns_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         unique case (state_reg)
            IDLE, DONE: begin
               if (bus.start) begin
                  m_reg     <= {{2{ext_m}}, bus.mpcnd};
                  q_reg     <= {{(QW - WIDTH){ext_q}}, bus.mplier};
                  acc_reg   <= '0;
                  q_m1_reg  <= 1'b0;
                  cnt_reg   <= '0;
                  uns_reg   <= uns_in;
                  state_reg <= ITER;
                  busy_reg  <= 1'b1;
               end else begin
                  state_reg <= IDLE;
               end
            end
            ITER: begin
               acc_reg  <= acc_next;
               q_reg    <= q_next;
               q_m1_reg <= q_reg[1];
               cnt_reg  <= cnt_reg + 1'b1;
               if (cnt_reg == last_cnt) begin
                  prd_reg   <= prd_next;
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.prd  = prd_reg;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult at WIDTH=8: latency, corner products,
// start-while-busy, mid-run reset and back-to-back starts.
module tb_booth_r4_seq_mult;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   pulses;

   booth_r4_seq_mult_if #(.WIDTH(8)) bus ();

   booth_r4_seq_mult #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Start at the current cycle (cycle 0); busy expected in cycles 1-4, done in cycle 5.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string tag);
      bus.start  = 1'b1;
      bus.mplier = a;
      bus.mpcnd  = b;
      tick();
      bus.start  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk({tag, " busy"}, 16'(bus.busy), 16'h1);
         chk({tag, " nodone"}, 16'(bus.done), 16'h0);
         tick();
      end
      chk({tag, " done"}, 16'(bus.done), 16'h1);
      chk({tag, " idle"}, 16'(bus.busy), 16'h0);
      chk({tag, " prd"}, bus.prd, exp);
      tick();
      chk({tag, " pulse1"}, 16'(bus.done), 16'h0);
      chk({tag, " hold"}, bus.prd, exp);
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.mplier = '0;
      bus.mpcnd  = '0;
`ifdef BOOTH_UNSIGNED_EN
      bus.is_signed = 1'b1;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk("rst busy", 16'(bus.busy), 16'h0);
      chk("rst done", 16'(bus.done), 16'h0);
      chk("rst prd", bus.prd, 16'h0000);

      run_op(8'd7, 8'd3, 16'h0015, "7x3");
      run_op(8'h80, 8'h80, 16'h4000, "m128xm128");
      run_op(8'hFF, 8'h7F, 16'hFF81, "m1x127");
      run_op(8'd3, 8'hFB, 16'hFFF1, "3xm5");
      run_op(8'hF9, 8'hF9, 16'h0031, "m7xm7");
      run_op(8'h7F, 8'h80, 16'hC080, "127xm128");
      run_op(8'h7F, 8'h7F, 16'h3F01, "127x127");
      run_op(8'h00, 8'h55, 16'h0000, "0x85");

      // start held through ITER with changing operands must be ignored
      bus.start  = 1'b1;
      bus.mplier = 8'd7;
      bus.mpcnd  = 8'd3;
      tick();
      bus.mplier = 8'd5;
      bus.mpcnd  = 8'd5;
      for (int i = 1; i <= 4; i++) begin
         chk("hold busy", 16'(bus.busy), 16'h1);
         if (i == 4) bus.start = 1'b0;
         tick();
      end
      chk("hold done", 16'(bus.done), 16'h1);
      chk("hold prd", bus.prd, 16'h0015);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      chk("hold one pulse", 16'(pulses), 16'h0);

      // reset in cycle 2 of an operation aborts it
      bus.start  = 1'b1;
      bus.mplier = 8'd9;
      bus.mpcnd  = 8'd9;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", 16'(bus.busy), 16'h0);
      chk("abort done", 16'(bus.done), 16'h0);
      chk("abort prd", bus.prd, 16'h0000);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      chk("abort no done", 16'(pulses), 16'h0);

      // back-to-back: start asserted in the DONE cycle
      bus.start  = 1'b1;
      bus.mplier = 8'd5;
      bus.mpcnd  = 8'hFA;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      chk("b2b done1", 16'(bus.done), 16'h1);
      chk("b2b prd1", bus.prd, 16'hFFE2);
      bus.start  = 1'b1;
      bus.mplier = 8'd9;
      bus.mpcnd  = 8'd9;
      tick();
      bus.start = 1'b0;
      chk("b2b no gap", 16'(bus.busy), 16'h1);
      tick();
      chk("b2b prd stable", bus.prd, 16'hFFE2);
      for (int i = 2; i <= 4; i++) tick();
      chk("b2b done2", 16'(bus.done), 16'h1);
      chk("b2b prd2", bus.prd, 16'h0051);
      tick();

`ifdef BOOTH_UNSIGNED_EN
      bus.is_signed = 1'b0;
      bus.start     = 1'b1;
      bus.mplier    = 8'hFF;
      bus.mpcnd     = 8'hFF;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk("uns busy", 16'(bus.busy), 16'h1);
         tick();
      end
      chk("uns done", 16'(bus.done), 16'h1);
      chk("uns prd", bus.prd, 16'hFE01);
      bus.is_signed = 1'b1;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
